// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch stage and its neighbours: the instruction
// memory (cpu_pc / cpu_instruction), decode control (stall, branch, jump)
// and the IF/ID pipeline register outputs.
// The master modport is the fetch stage itself.
// Optional macro FETCH_PERF_CNT_EN adds the two performance counters.
interface instruction_fetch_if #(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  stall;
  logic                  branch_taken;
  logic [PC_WIDTH-1:0]   branch_offset;
  logic                  jump;
  logic [PC_WIDTH-5:0]   jump_addr;
  logic [DATA_WIDTH-1:0] cpu_instruction;
  logic [PC_WIDTH-1:0]   cpu_pc;
  logic [DATA_WIDTH-1:0] ifid_instr;
  logic [PC_WIDTH-1:0]   ifid_pc_plus2;
  logic                  ifid_valid;
  logic                  fetch_halt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]           perf_fetch_cnt;
  logic [31:0]           perf_stall_cnt;
`endif

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_addr, cpu_instruction,
`ifdef FETCH_PERF_CNT_EN
    output perf_fetch_cnt, perf_stall_cnt,
`endif
    output cpu_pc, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_halt
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_addr, cpu_instruction,
`ifdef FETCH_PERF_CNT_EN
    input  perf_fetch_cnt, perf_stall_cnt,
`endif
    input  cpu_pc, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_halt
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage of the 16-bit MIPS pipeline. Owns the PC, drives it to the
// instruction memory and registers the returned instruction into IF/ID.
// Update priority per edge: reset > jump > branch > stall > halt > sequential.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module instruction_fetch #(
  parameter int                 PC_WIDTH   = 16,
  parameter int                 DATA_WIDTH = 16,
  parameter int                 INSTR_NUM  = 15,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               reset,
  instruction_fetch_if.master bus
);

  // Word-index limit: any PC whose word index reaches this is past the program.
  localparam logic [PC_WIDTH-1:0] INSTR_LIMIT = PC_WIDTH'(INSTR_NUM);

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_WIDTH-1:0]   ifid_pc_plus2_q, ifid_pc_plus2_d;
  logic                  ifid_valid_q, ifid_valid_d;

  logic [PC_WIDTH-1:0]   pc_plus2;
  logic [PC_WIDTH-1:0]   jump_target;
  logic [PC_WIDTH-1:0]   branch_target;
  logic                  halted;
  logic                  fetch_load;
  logic                  stall_hold;

  assign pc_plus2      = pc_q + PC_WIDTH'(2);
  // Jump keeps the top three bits of the delay-slot PC, target is a word index.
  assign jump_target   = {ifid_pc_plus2_q[PC_WIDTH-1 -: 3], bus.jump_addr, 1'b0};
  // Branch offset is in words; the shift drops the top bit, i.e. modulo 2^PC_WIDTH.
  assign branch_target = ifid_pc_plus2_q + {bus.branch_offset[PC_WIDTH-2:0], 1'b0};
  assign halted        = ({1'b0, pc_q[PC_WIDTH-1:1]} >= INSTR_LIMIT);

  // Next-state selection; a redirect beats stall because the stalled slot is wrong-path.
  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus2_d = ifid_pc_plus2_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_load      = 1'b0;
    stall_hold      = 1'b0;
    if (bus.jump) begin
      pc_d         = jump_target;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else if (bus.branch_taken) begin
      pc_d         = branch_target;
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else if (bus.stall) begin
      stall_hold   = 1'b1;
    end else if (halted) begin
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else begin
      pc_d            = pc_plus2;
      ifid_instr_d    = bus.cpu_instruction;
      ifid_pc_plus2_d = pc_plus2;
      ifid_valid_d    = 1'b1;
      fetch_load      = 1'b1;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q            <= RESET_PC;
      ifid_instr_q    <= '0;
      ifid_pc_plus2_q <= '0;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus2_q <= ifid_pc_plus2_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

  assign bus.cpu_pc        = pc_q;
  assign bus.ifid_instr    = ifid_instr_q;
  assign bus.ifid_pc_plus2 = ifid_pc_plus2_q;
  assign bus.ifid_valid    = ifid_valid_q;
  assign bus.fetch_halt    = halted;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  // Saturating counters of valid fetches and plain (non-redirected) stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fetch_load && (perf_fetch_q != 32'hFFFF_FFFF)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (stall_hold && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_q;
  assign bus.perf_stall_cnt = perf_stall_q;
`else
  // Counters absent: the load/stall qualifiers have no consumer.
  logic unused_perf;
  assign unused_perf = fetch_load ^ stall_hold;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized decode control checked against a behavioural model.
module tb_instruction_fetch;
  localparam int INSTR_NUM = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if #(.PC_WIDTH(16), .DATA_WIDTH(16)) bus ();

  instruction_fetch #(
    .PC_WIDTH(16), .DATA_WIDTH(16), .INSTR_NUM(INSTR_NUM), .RESET_PC(16'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory stand-in: combinational read, zero past the program.
  logic [15:0] mem [0:INSTR_NUM-1];
  assign bus.cpu_instruction = (bus.cpu_pc[15:1] < 15'(INSTR_NUM)) ? mem[bus.cpu_pc[4:1]] : 16'h0;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (plain integers).
  int          m_pc, m_pp2;
  logic [15:0] m_instr;
  bit          m_valid;
  longint      m_fc, m_sc;

  function automatic logic [15:0] mem_at(input int pc);
    int idx = pc / 2;
    return (idx < INSTR_NUM) ? mem[idx] : 16'h0;
  endfunction

  function automatic bit m_halted();
    return (m_pc / 2) >= INSTR_NUM;
  endfunction

  task automatic model_step(input bit rst, st, br, jp, input logic [15:0] off, input logic [11:0] ja);
    int soff;
    if (rst) begin
      m_pc = 0; m_pp2 = 0; m_instr = 16'h0; m_valid = 0; m_fc = 0; m_sc = 0;
    end else if (jp) begin
      m_pc = (m_pp2 / 8192) * 8192 + int'(ja) * 2;
      m_instr = 16'h0; m_valid = 0;
    end else if (br) begin
      soff = int'($signed(off));
      m_pc = (m_pp2 + 2 * soff + 4 * 65536) % 65536;
      m_instr = 16'h0; m_valid = 0;
    end else if (st) begin
      if (m_sc < 64'hFFFF_FFFF) m_sc++;
    end else if (m_halted()) begin
      m_instr = 16'h0; m_valid = 0;
    end else begin
      m_instr = mem_at(m_pc);
      m_pc    = (m_pc + 2) % 65536;
      m_pp2   = m_pc;
      m_valid = 1;
      if (m_fc < 64'hFFFF_FFFF) m_fc++;
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
  task automatic step(input bit rst, st, br, jp, input logic [15:0] off, input logic [11:0] ja);
    reset = rst; bus.stall = st; bus.branch_taken = br; bus.jump = jp;
    bus.branch_offset = off; bus.jump_addr = ja;
    @(posedge clk);
    model_step(rst, st, br, jp, off, ja);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0, 12'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 16'h0, 12'h0);
    step(1, 0, 0, 0, 16'h0, 12'h0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.cpu_pc !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0000", bus.cpu_pc); end
    checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ifid_valid); end
    checks++; if (bus.ifid_instr !== 16'h0 || bus.ifid_pc_plus2 !== 16'h0) begin errors++; $display("FAIL reset_ifid: got instr %h pc2 %h expected 0000 0000", bus.ifid_instr, bus.ifid_pc_plus2); end
    checks++; if (bus.fetch_halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", bus.fetch_halt); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (bus.perf_fetch_cnt !== 32'd0 || bus.perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d %0d expected 0 0", bus.perf_fetch_cnt, bus.perf_stall_cnt); end
`endif
    idle(1);
    checks++; if (bus.ifid_instr !== 16'h1234) begin errors++; $display("FAIL first_fetch_instr: got %h expected 1234", bus.ifid_instr); end
    checks++; if (bus.ifid_pc_plus2 !== 16'd2 || bus.cpu_pc !== 16'd2 || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL first_fetch_pc: got pc2 %h pc %h valid %b expected 0002 0002 1", bus.ifid_pc_plus2, bus.cpu_pc, bus.ifid_valid); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle(1);
      checks++;
      if (bus.cpu_pc !== 16'(2 * (k + 1)) || bus.ifid_pc_plus2 !== 16'(2 * (k + 1)) || bus.ifid_instr !== mem[k]) begin
        errors++; $display("FAIL seq_run[%0d]: got pc %h pc2 %h instr %h expected %h %h %h", k, bus.cpu_pc, bus.ifid_pc_plus2, bus.ifid_instr, 16'(2 * (k + 1)), 16'(2 * (k + 1)), mem[k]);
      end
    end
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    do_reset();
    idle(3);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 16'h0, 12'h0);
      checks++;
      if (bus.cpu_pc !== 16'd6 || bus.ifid_instr !== mem[2] || bus.ifid_pc_plus2 !== 16'd6 || bus.ifid_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got pc %h instr %h pc2 %h valid %b expected 0006 %h 0006 1", k, bus.cpu_pc, bus.ifid_instr, bus.ifid_pc_plus2, bus.ifid_valid, mem[2]);
      end
    end
    idle(1);
    checks++; if (bus.cpu_pc !== 16'd8 || bus.ifid_instr !== mem[3]) begin errors++; $display("FAIL stall_release: got pc %h instr %h expected 0008 %h", bus.cpu_pc, bus.ifid_instr, mem[3]); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (bus.perf_stall_cnt !== 32'd3 || bus.perf_fetch_cnt !== 32'd4) begin errors++; $display("FAIL stall_perf: got %0d %0d expected 3 4", bus.perf_stall_cnt, bus.perf_fetch_cnt); end
`endif
    $display("test_stall done");
  endtask

  task automatic test_branch();
    for (int s = 0; s < 2; s++) begin
      do_reset();
      idle(2);
      step(0, s[0], 1, 0, 16'hFFFE, 12'h0);
      checks++;
      if (bus.cpu_pc !== 16'h0 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0) begin
        errors++; $display("FAIL branch_back stall=%0d: got pc %h valid %b instr %h expected 0000 0 0000", s, bus.cpu_pc, bus.ifid_valid, bus.ifid_instr);
      end
    end
    $display("test_branch done");
  endtask

  task automatic test_jump_priority();
    do_reset();
    idle(1);
    step(0, 0, 1, 1, 16'h0003, 12'd5);
    checks++; if (bus.cpu_pc !== 16'd10 || bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL jump_wins: got pc %h valid %b expected 000a 0", bus.cpu_pc, bus.ifid_valid); end
    $display("test_jump_priority done");
  endtask

  task automatic test_halt();
    do_reset();
    idle(15);
    checks++; if (bus.cpu_pc !== 16'd30 || bus.fetch_halt !== 1'b1 || bus.ifid_instr !== mem[14]) begin errors++; $display("FAIL halt_reach: got pc %h halt %b instr %h expected 001e 1 %h", bus.cpu_pc, bus.fetch_halt, bus.ifid_instr, mem[14]); end
    idle(3);
    checks++; if (bus.cpu_pc !== 16'd30 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 16'h0) begin errors++; $display("FAIL halt_hold: got pc %h valid %b instr %h expected 001e 0 0000", bus.cpu_pc, bus.ifid_valid, bus.ifid_instr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (bus.perf_fetch_cnt !== 32'd15 || bus.perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL halt_perf: got %0d %0d expected 15 0", bus.perf_fetch_cnt, bus.perf_stall_cnt); end
`endif
    step(0, 0, 0, 1, 16'h0, 12'd2);
    checks++; if (bus.cpu_pc !== 16'd4 || bus.fetch_halt !== 1'b0) begin errors++; $display("FAIL halt_redirect: got pc %h halt %b expected 0004 0", bus.cpu_pc, bus.fetch_halt); end
    $display("test_halt done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle(3);
    step(1, 1, 1, 1, 16'h0005, 12'd7);
    checks++; if (bus.cpu_pc !== 16'h0 || bus.ifid_valid !== 1'b0 || bus.ifid_pc_plus2 !== 16'h0) begin errors++; $display("FAIL reset_mid: got pc %h valid %b pc2 %h expected 0000 0 0000", bus.cpu_pc, bus.ifid_valid, bus.ifid_pc_plus2); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    bit rst, st, br, jp;
    logic [15:0] off;
    logic [11:0] ja;
    int bad;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(63) == 0);
      st  = ($urandom_range(3) == 0);
      br  = ($urandom_range(7) == 0);
      jp  = ($urandom_range(15) == 0);
      off = 16'($signed($urandom_range(40)) - 20);
      ja  = ($urandom_range(7) == 0) ? 12'($urandom) : 12'($urandom_range(18));
      step(rst, st, br, jp, off, ja);
      bad = 0;
      checks++;
      if (bus.cpu_pc !== 16'(m_pc) || bus.ifid_instr !== m_instr || bus.ifid_pc_plus2 !== 16'(m_pp2) ||
          bus.ifid_valid !== m_valid || bus.fetch_halt !== m_halted()) begin
        errors++; bad = 1;
        $display("FAIL random[%0d]: got pc %h instr %h pc2 %h valid %b halt %b expected %h %h %h %b %b", i,
                 bus.cpu_pc, bus.ifid_instr, bus.ifid_pc_plus2, bus.ifid_valid, bus.fetch_halt,
                 16'(m_pc), m_instr, 16'(m_pp2), m_valid, m_halted());
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (bus.perf_fetch_cnt !== 32'(m_fc) || bus.perf_stall_cnt !== 32'(m_sc)) begin
        errors++; bad = 1;
        $display("FAIL random_perf[%0d]: got %0d %0d expected %0d %0d", i, bus.perf_fetch_cnt, bus.perf_stall_cnt, m_fc, m_sc);
      end
`endif
      if (bad == 0 && (i % 100) == 0) $display("random[%0d] rst=%0b st=%0b br=%0b jp=%0b pc=%h ok", i, rst, st, br, jp, bus.cpu_pc);
    end
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < INSTR_NUM; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    reset = 1'b1; bus.stall = 0; bus.branch_taken = 0; bus.jump = 0;
    bus.branch_offset = 16'h0; bus.jump_addr = 12'h0;
    m_pc = 0; m_pp2 = 0; m_instr = 16'h0; m_valid = 0; m_fc = 0; m_sc = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
